// File: rtl/iecdrv_sd_arbiter.sv
// iecdrv_sd_arbiter: round-robin share of the host SD block port between IEC drives.
// Optional REQ watchdog enabled by defining IECDRV_SD_ARB_TIMEOUT_EN.
module iecdrv_sd_arbiter #(
    parameter int          NDRV    = 2,
    parameter logic [23:0] TIMEOUT = 24'hFFFFFF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NDRV*32-1:0]   drv_lba,
    input  logic [NDRV*6-1:0]    drv_blk_cnt,
    input  logic [NDRV-1:0]      drv_rd,
    input  logic [NDRV-1:0]      drv_wr,
    input  logic [NDRV*8-1:0]    drv_buff_din,
    output logic [NDRV-1:0]      drv_ack,
    output logic [NDRV-1:0]      drv_buff_wr,
    output logic [31:0]          sd_lba,
    output logic [5:0]           sd_blk_cnt,
    output logic                 sd_rd,
    output logic                 sd_wr,
    input  logic                 sd_ack,
    input  logic                 sd_buff_wr,
    output logic [7:0]           sd_buff_din,
    output logic [1:0]           gnt,
    output logic                 arb_err
);

    typedef enum logic [1:0] {IDLE, REQ, XFER, RELEASE} state_t;

    state_t          state;
    logic [NDRV-1:0] pend;
    logic            found;
    logic [1:0]      pick;
    int              rank;
    int              best;
    logic [31:0]     pick_lba;
    logic [5:0]      pick_cnt;
    logic            pick_wr;
    logic            gnt_busy;
    logic [7:0]      din_mux;

    assign pend        = drv_rd | drv_wr;
    assign sd_buff_din = din_mux;

    // Round-robin search: lowest distance above the last grant wins.
    always_comb begin
        found = 1'b0;
        pick  = gnt;
        rank  = 0;
        best  = NDRV;
        for (int j = 0; j < NDRV; j++) begin
            rank = (j + 2 * NDRV - int'(gnt) - 1) % NDRV;
            if (pend[j] && rank < best) begin
                best  = rank;
                found = 1'b1;
                pick  = 2'(j);
            end
        end
    end

    // Per-drive selects for the candidate and for the current grant.
    always_comb begin
        pick_lba = '0;
        pick_cnt = '0;
        pick_wr  = 1'b0;
        gnt_busy = 1'b0;
        din_mux  = '0;
        for (int i = 0; i < NDRV; i++) begin
            if (pick == 2'(i)) begin
                pick_lba = drv_lba[32*i +: 32];
                pick_cnt = drv_blk_cnt[6*i +: 6];
                pick_wr  = drv_wr[i];
            end
            if (gnt == 2'(i)) begin
                gnt_busy = pend[i];
                din_mux  = drv_buff_din[8*i +: 8];
            end
        end
    end

    // Zero-latency routing of host ack and buffer strobe to the granted drive.
    always_comb begin
        drv_ack     = '0;
        drv_buff_wr = '0;
        for (int i = 0; i < NDRV; i++) begin
            if (state == XFER && gnt == 2'(i)) begin
                drv_ack[i]     = sd_ack;
                drv_buff_wr[i] = sd_buff_wr & sd_ack;
            end
        end
    end

`ifdef IECDRV_SD_ARB_TIMEOUT_EN
    logic [23:0] to_cnt;

    // REQ watchdog: loaded on grant, pulses arb_err when it expires unacked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt  <= '0;
            arb_err <= 1'b0;
        end else begin
            arb_err <= 1'b0;
            if (state == IDLE && found) begin
                to_cnt <= TIMEOUT;
            end else if (state == REQ && !sd_ack) begin
                if (to_cnt == 24'd0) begin
                    arb_err <= 1'b1;
                end else begin
                    to_cnt <= to_cnt - 24'd1;
                end
            end
        end
    end
`else
    assign arb_err = 1'b0;
`endif

    // Grant FSM with registered host request, LBA and block count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            gnt        <= 2'd0;
            sd_lba     <= '0;
            sd_blk_cnt <= '0;
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        gnt        <= pick;
                        sd_lba     <= pick_lba;
                        sd_blk_cnt <= pick_cnt;
                        sd_wr      <= pick_wr;
                        sd_rd      <= ~pick_wr;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (sd_ack) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                        state <= XFER;
                    end
`ifdef IECDRV_SD_ARB_TIMEOUT_EN
                    else if (to_cnt == 24'd0) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                        state <= IDLE;
                    end
`endif
                end
                XFER: begin
                    if (!sd_ack) state <= RELEASE;
                end
                RELEASE: begin
                    if (!gnt_busy) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iecdrv_sd_arbiter.sv
// tb_iecdrv_sd_arbiter: randomized round-robin bench with a queue-free
// behavioural model of pending drives and last grant.
module tb_iecdrv_sd_arbiter;
    localparam int N = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N*32-1:0] drv_lba;
    logic [N*6-1:0]  drv_blk_cnt;
    logic [N-1:0]    drv_rd;
    logic [N-1:0]    drv_wr;
    logic [N*8-1:0]  drv_buff_din;
    logic [N-1:0]    drv_ack;
    logic [N-1:0]    drv_buff_wr;
    logic [31:0]     sd_lba;
    logic [5:0]      sd_blk_cnt;
    logic            sd_rd;
    logic            sd_wr;
    logic            sd_ack;
    logic            sd_buff_wr;
    logic [7:0]      sd_buff_din;
    logic [1:0]      gnt;
    logic            arb_err;

    int n_pass = 0;
    int n_tot  = 0;

    int          mg;
    bit          m_pend [N];
    bit          m_wr   [N];
    logic [31:0] m_lba  [N];
    logic [5:0]  m_cnt  [N];

    iecdrv_sd_arbiter #(.NDRV(N), .TIMEOUT(24'd16)) dut (
        .clk(clk), .reset(reset),
        .drv_lba(drv_lba), .drv_blk_cnt(drv_blk_cnt),
        .drv_rd(drv_rd), .drv_wr(drv_wr),
        .drv_buff_din(drv_buff_din),
        .drv_ack(drv_ack), .drv_buff_wr(drv_buff_wr),
        .sd_lba(sd_lba), .sd_blk_cnt(sd_blk_cnt),
        .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_ack(sd_ack), .sd_buff_wr(sd_buff_wr),
        .sd_buff_din(sd_buff_din),
        .gnt(gnt), .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1);
    end

    task automatic nc;
        @(negedge clk);
    endtask

    task automatic set_req(input int d, input bit rd, input bit wr,
                           input logic [31:0] lba, input logic [5:0] cnt);
        drv_rd[d] = rd;
        drv_wr[d] = wr;
        drv_lba[32*d +: 32] = lba;
        drv_blk_cnt[6*d +: 6] = cnt;
        m_pend[d] = rd | wr;
        m_wr[d]   = wr;
        m_lba[d]  = lba;
        m_cnt[d]  = cnt;
    endtask

    task automatic clr_req(input int d);
        drv_rd[d] = 1'b0;
        drv_wr[d] = 1'b0;
        m_pend[d] = 1'b0;
    endtask

    function automatic int rr_next();
        for (int k = 1; k <= N; k++) begin
            if (m_pend[(mg + k) % N]) return (mg + k) % N;
        end
        return -1;
    endfunction

    task automatic serve(input int ed, input int dly, input int alen,
                         output int lat);
        bit          seen;
        logic [N-1:0] ea;
        logic [N-1:0] eb;
        seen = 1'b0;
        lat  = 0;
        for (int t = 0; t < 40; t++) begin
            nc;
            #1;
            if (sd_rd | sd_wr) begin
                seen = 1'b1;
                lat  = t + 1;
                break;
            end
        end
        n_tot++;
        if (!seen) begin
            $display("FAIL serve_wait: no request seen, want drive %0d", ed);
            return;
        end
        n_pass++;
        n_tot++;
        if (gnt !== ed[1:0]) $display("FAIL gnt: got %0d want %0d", gnt, ed);
        else n_pass++;
        n_tot++;
        if (sd_wr !== m_wr[ed] || sd_rd !== !m_wr[ed])
            $display("FAIL rdwr: got rd=%b wr=%b want wr=%b", sd_rd, sd_wr, m_wr[ed]);
        else n_pass++;
        n_tot++;
        if (sd_lba !== m_lba[ed] || sd_blk_cnt !== m_cnt[ed])
            $display("FAIL lba_cnt: got %h/%0d want %h/%0d",
                     sd_lba, sd_blk_cnt, m_lba[ed], m_cnt[ed]);
        else n_pass++;
        n_tot++;
        if (arb_err !== 1'b0) $display("FAIL arb_err_idle: got %b want 0", arb_err);
        else n_pass++;
        drv_lba[32*ed +: 32] = $urandom;
        drv_blk_cnt[6*ed +: 6] = 6'($urandom);
        repeat (dly) nc;
        for (int c = 0; c < alen; c++) begin
            nc;
            sd_ack       = 1'b1;
            sd_buff_wr   = 1'($urandom);
            drv_buff_din = 16'($urandom);
            #1;
            if (c == 0) begin
                n_tot++;
                if ((sd_rd | sd_wr) !== 1'b1 || sd_lba !== m_lba[ed]
                    || sd_blk_cnt !== m_cnt[ed])
                    $display("FAIL req_hold: rd=%b wr=%b lba=%h want lba %h",
                             sd_rd, sd_wr, sd_lba, m_lba[ed]);
                else n_pass++;
            end else begin
                ea = '0;
                ea[ed] = 1'b1;
                eb = '0;
                eb[ed] = sd_buff_wr;
                n_tot++;
                if (drv_ack !== ea || drv_buff_wr !== eb)
                    $display("FAIL route: ack=%b bw=%b want ack=%b bw=%b",
                             drv_ack, drv_buff_wr, ea, eb);
                else n_pass++;
                n_tot++;
                if ((sd_rd | sd_wr) !== 1'b0)
                    $display("FAIL req_drop: rd=%b wr=%b want 0", sd_rd, sd_wr);
                else n_pass++;
            end
            n_tot++;
            if (sd_buff_din !== drv_buff_din[8*ed +: 8])
                $display("FAIL buff_din: got %h want %h",
                         sd_buff_din, drv_buff_din[8*ed +: 8]);
            else n_pass++;
        end
        nc;
        sd_ack     = 1'b0;
        sd_buff_wr = 1'b0;
        #1;
        n_tot++;
        if (drv_ack !== '0 || drv_buff_wr !== '0)
            $display("FAIL ack_fall: ack=%b bw=%b want 0", drv_ack, drv_buff_wr);
        else n_pass++;
        mg = ed;
    endtask

    task automatic finish_drv(input int d, input int hold);
        for (int h = 0; h < hold; h++) begin
            nc;
            #1;
            n_tot++;
            if ((sd_rd | sd_wr) !== 1'b0)
                $display("FAIL release_hold: rd=%b wr=%b want 0", sd_rd, sd_wr);
            else n_pass++;
        end
        nc;
        clr_req(d);
    endtask

    task automatic test_reset;
        reset        = 1'b1;
        drv_lba      = '0;
        drv_blk_cnt  = '0;
        drv_rd       = '0;
        drv_wr       = '0;
        drv_buff_din = '0;
        sd_ack       = 1'b0;
        sd_buff_wr   = 1'b0;
        for (int d = 0; d < N; d++) m_pend[d] = 1'b0;
        mg = 0;
        repeat (3) nc;
        reset = 1'b0;
        #1;
        n_tot++;
        if ({sd_rd, sd_wr, arb_err, drv_ack, drv_buff_wr, gnt} !== '0
            || sd_lba !== '0 || sd_blk_cnt !== '0)
            $display("FAIL reset: rd=%b wr=%b err=%b ack=%b bw=%b gnt=%0d lba=%h cnt=%0d want 0",
                     sd_rd, sd_wr, arb_err, drv_ack, drv_buff_wr, gnt, sd_lba, sd_blk_cnt);
        else n_pass++;
    endtask

    task automatic test_single;
        int lat;
        nc;
        set_req(0, 1'b1, 1'b0, 32'h1F, 6'd31);
        serve(0, 2, 256, lat);
        n_tot++;
        if (lat !== 1) $display("FAIL single_latency: got %0d want 1", lat);
        else n_pass++;
        finish_drv(0, 0);
        nc;
        #1;
        n_tot++;
        if ((sd_rd | sd_wr) !== 1'b0)
            $display("FAIL single_idle: rd=%b wr=%b want 0", sd_rd, sd_wr);
        else n_pass++;
    endtask

    task automatic test_rr_pair;
        int lat;
        int ed;
        nc;
        set_req(0, 1'b1, 1'b0, 32'h100, 6'd5);
        set_req(1, 1'b1, 1'b0, 32'h200, 6'd7);
        for (int k = 0; k < 2; k++) begin
            ed = rr_next();
            serve(ed, 1, 4, lat);
            finish_drv(ed, 0);
        end
    endtask

    task automatic test_wr_priority;
        int lat;
        nc;
        set_req(rr_next() < 0 ? 0 : 0, 1'b1, 1'b1, 32'hABCD, 6'd17);
        serve(0, 0, 6, lat);
        finish_drv(0, 1);
    endtask

    task automatic test_release_hold;
        int lat;
        nc;
        set_req(0, 1'b1, 1'b0, 32'h55, 6'd3);
        serve(0, 1, 3, lat);
        set_req(1, 1'b1, 1'b0, 32'h77, 6'd9);
        finish_drv(0, 5);
        serve(rr_next(), 0, 2, lat);
        finish_drv(1, 0);
    endtask

    task automatic test_random;
        int  lat;
        int  ed;
        bit  any;
        bit  wr;
        for (int it = 0; it < 30; it++) begin
            nc;
            any = 1'b0;
            for (int d = 0; d < N; d++) begin
                if (!m_pend[d] && $urandom_range(0, 1) == 1) begin
                    wr = 1'($urandom_range(0, 1));
                    set_req(d, wr ? 1'($urandom_range(0, 1)) : 1'b1, wr,
                            $urandom, 6'($urandom));
                end
                any = any | m_pend[d];
            end
            if (!any) set_req(int'($urandom_range(0, N - 1)), 1'b1, 1'b0,
                              $urandom, 6'($urandom));
            ed = rr_next();
            serve(ed, int'($urandom_range(0, 5)), int'($urandom_range(1, 20)), lat);
            n_tot++;
            if (lat !== 1) $display("FAIL rand_latency: got %0d want 1", lat);
            else n_pass++;
            finish_drv(ed, int'($urandom_range(0, 3)));
        end
        while (rr_next() >= 0) begin
            ed = rr_next();
            serve(ed, 0, 2, lat);
            finish_drv(ed, 0);
        end
    endtask

    task automatic test_reset_mid;
        bit seen;
        nc;
        set_req(1, 1'b1, 1'b0, 32'hDEAD, 6'd12);
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            nc;
            #1;
            if (sd_rd) begin
                seen = 1'b1;
                break;
            end
        end
        n_tot++;
        if (!seen) $display("FAIL mid_wait: no request seen");
        else n_pass++;
        nc;
        sd_ack = 1'b1;
        nc;
        sd_buff_wr = 1'b1;
        #1;
        n_tot++;
        if (drv_ack !== 2'b10 || drv_buff_wr !== 2'b10)
            $display("FAIL mid_route: ack=%b bw=%b want 10/10", drv_ack, drv_buff_wr);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_tot++;
        if ({sd_rd, sd_wr, drv_ack, drv_buff_wr, gnt} !== '0)
            $display("FAIL mid_reset: rd=%b wr=%b ack=%b bw=%b gnt=%0d want 0",
                     sd_rd, sd_wr, drv_ack, drv_buff_wr, gnt);
        else n_pass++;
        sd_ack     = 1'b0;
        sd_buff_wr = 1'b0;
        clr_req(1);
        nc;
        reset = 1'b0;
        mg = 0;
        set_req(0, 1'b0, 1'b1, 32'h42, 6'd1);
        nc;
        #1;
        n_tot++;
        if (sd_wr !== 1'b1) $display("FAIL req_wr_up: got %b want 1", sd_wr);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_tot++;
        if ((sd_rd | sd_wr) !== 1'b0)
            $display("FAIL req_reset: rd=%b wr=%b want 0", sd_rd, sd_wr);
        else n_pass++;
        clr_req(0);
        nc;
        reset = 1'b0;
        mg = 0;
    endtask

`ifdef IECDRV_SD_ARB_TIMEOUT_EN
    task automatic test_timeout;
        int hi;
        int lat;
        nc;
        set_req(0, 1'b1, 1'b0, 32'h1000, 6'd2);
        hi = 0;
        for (int t = 0; t < 40; t++) begin
            nc;
            if (t == 1) set_req(1, 1'b1, 1'b0, 32'h2000, 6'd4);
            #1;
            if (sd_rd && gnt == 2'd0) hi++;
            else break;
        end
        n_tot++;
        if (hi !== 17) $display("FAIL to_cycles: got %0d want 17", hi);
        else n_pass++;
        n_tot++;
        if (arb_err !== 1'b1 || sd_rd !== 1'b0)
            $display("FAIL to_pulse: err=%b rd=%b want 1/0", arb_err, sd_rd);
        else n_pass++;
        nc;
        #1;
        n_tot++;
        if (arb_err !== 1'b0 || sd_rd !== 1'b1 || gnt !== 2'd1 || sd_lba !== m_lba[1])
            $display("FAIL to_next: err=%b rd=%b gnt=%0d lba=%h want 0/1/1/%h",
                     arb_err, sd_rd, gnt, sd_lba, m_lba[1]);
        else n_pass++;
        mg = 0;
        serve(rr_next(), 0, 3, lat);
        finish_drv(1, 0);
        serve(rr_next(), 0, 3, lat);
        finish_drv(0, 0);
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_rr_pair;
        test_wr_priority;
        test_release_hold;
        test_random;
        test_reset_mid;
`ifdef IECDRV_SD_ARB_TIMEOUT_EN
        test_timeout;
`endif
        repeat (2) nc;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
